// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_e;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Two-way round-robin select; a locked owner that is still requesting wins outright.
module rr_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_e owner,
  input  logic   last,   // 1 = port 1 was granted last
  output logic   pick0,
  output logic   pick1
);

  // Lock override first, then the single requester, then the port that was not served last.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (owner == OWN_P0 && req0) begin
      pick0 = 1'b1;
    end else if (owner == OWN_P1 && req1) begin
      pick1 = 1'b1;
    end else if (req0 && req1) begin
      pick0 = last;
      pick1 = !last;
    end else begin
      pick0 = req0;
      pick1 = req1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the core load/store path (port 0)
// and the DMA/debug loader (port 1), with round robin and bounded burst lock.
//
// state    | meaning
// OWN_NONE | no lock held, round robin decides
// OWN_P0   | port 0 holds a burst lock
// OWN_P1   | port 1 holds a burst lock
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4,
  parameter bit CORE_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pick0, pick1;
  logic             lock_w;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .owner (owner_q),
    .last  (last_q),
    .pick0 (pick0),
    .pick1 (pick1)
  );

  // Grants are forced low while reset is asserted so the memory sees no access.
  always_comb begin
    gnt0 = pick0 & rst_n;
    gnt1 = pick1 & rst_n;
  end

  // Steer the winner onto the shared memory bus; idle bus is all zero.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (gnt0) begin
      mem_access_addr = addr0;
      mem_write_data  = wdata0;
      mem_write_en    = we0;
      mem_read        = !we0;
    end else if (gnt1) begin
      mem_access_addr = addr1;
      mem_write_data  = wdata1;
      mem_write_en    = we1;
      mem_read        = !we1;
    end
  end

  // Ownership/burst bookkeeping; no grant means any lock holder dropped its request.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    lock_w  = gnt0 ? lock0 : lock1;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (lock_w && (cnt_inc < MAX_CNT)) begin
        owner_d = gnt0 ? OWN_P0 : OWN_P1;
        cnt_d   = cnt_inc;
      end else begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    end else begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= CORE_PRIO;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture read data at the end of a read grant; rvalid pulses the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_read_data;
      if (gnt1 && !we1) rdata1 <= mem_read_data;
    end
  end

  always_comb busy = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, busy;

  logic [15:0] mem [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cnt0, cnt1;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_BURST(4), .CORE_PRIO(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  assign mem_read_data = mem[mem_access_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    idle_inputs();
    rst_n = 0;
    #2;
    req0 = 1; addr0 = 16'd9;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_addr", mem_access_addr, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rdata0", rdata0, 0);
    next_cycle();
    idle_inputs();
    rst_n = 1;
    #1;

    // single read from port 0
    req0 = 1; addr0 = 16'd3;
    #1;
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_mem_read", mem_read, 1);
    check("rd_addr", mem_access_addr, 3);
    next_cycle();
    idle_inputs();
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata0", rdata0, 16'h1003);
    check("rd_rvalid1", rvalid1, 0);
    next_cycle();
    check("rd_rvalid0_pulse", rvalid0, 0);
    check("rd_rdata0_hold", rdata0, 16'h1003);

    // continuous contention, no lock: strict alternation starting with port 0
    do_reset();
    req0 = 1; addr0 = 16'd10; req1 = 1; addr1 = 16'd20;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1) ? 1 : 0);
      cnt0 += int'(gnt0); cnt1 += int'(gnt1);
      next_cycle();
    end
    check("rr_total0", cnt0, 4);
    check("rr_total1", cnt1, 4);
    idle_inputs();

    // write from port 1 then read-back from port 0
    do_reset();
    req1 = 1; we1 = 1; addr1 = 16'd5; wdata1 = 16'hA5A5;
    #1;
    check("wr_gnt1", gnt1, 1);
    check("wr_we", mem_write_en, 1);
    check("wr_data", mem_write_data, 16'hA5A5);
    next_cycle();
    idle_inputs();
    req0 = 1; addr0 = 16'd5;
    #1;
    check("rb_gnt0", gnt0, 1);
    check("rb_we", mem_write_en, 0);
    next_cycle();
    idle_inputs();
    check("rb_rvalid0", rvalid0, 1);
    check("rb_rdata0", rdata0, 16'hA5A5);
    check("rb_rvalid1", rvalid1, 0);

    // burst lock capped at four grants, then handover
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 16'd30; req1 = 1; addr1 = 16'd40;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bl_gnt0_%0d", i), gnt0, 1);
      next_cycle();
      check($sformatf("bl_busy_%0d", i), busy, (i < 3) ? 1 : 0);
    end
    #1;
    check("bl_handover_gnt1", gnt1, 1);
    check("bl_handover_gnt0", gnt0, 0);
    next_cycle();
    idle_inputs();

    // locked owner drops its request after two grants
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 16'd31; req1 = 1; addr1 = 16'd41;
    next_cycle();
    next_cycle();
    check("drop_busy_before", busy, 1);
    req0 = 0; lock0 = 0;
    #1;
    check("drop_gnt1", gnt1, 1);
    check("drop_gnt0", gnt0, 0);
    next_cycle();
    check("drop_busy_after", busy, 0);
    req1 = 0;
    req0 = 1; lock0 = 1;
    next_cycle();
    next_cycle();
    next_cycle();
    check("drop_cnt_cleared", busy, 1);
    idle_inputs();
    next_cycle();

    // reset mid locked read burst
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 16'd7; req1 = 1; addr1 = 16'd8;
    next_cycle();
    check("mr_busy", busy, 1);
    check("mr_rvalid_pre", rvalid0, 1);
    rst_n = 0;
    #1;
    check("mr_gnt0", gnt0, 0);
    check("mr_busy_rst", busy, 0);
    check("mr_mem_read", mem_read, 0);
    check("mr_addr", mem_access_addr, 0);
    check("mr_rvalid0", rvalid0, 0);
    check("mr_rdata0", rdata0, 0);
    next_cycle();
    check("mr_rvalid0_held", rvalid0, 0);
    rst_n = 1;
    #1;
    check("mr_rvalid0_release", rvalid0, 0);
    check("mr_tie_gnt0", gnt0, 1);
    check("mr_tie_gnt1", gnt1, 0);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
